inst_fetch_queue: RTL and testbench

Instruction prefetch queue between the CPU's instruction-fetch port and the combinational instruction ROM in the minimal SoC. Owns the fetch PC, reads the ROM one word per cycle while space remains, and buffers {pc, inst} pairs in a small FIFO. Delivers them to the decode stage over a valid/ready handshake. Branch/jump redirects flush the queue and restart fetch at the new PC.

---
 rtl/inst_fetch_queue.sv | 127 ++++++++++++
 tb/tb_inst_fetch_queue.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
// Instruction prefetch queue between the CPU fetch port and a combinational
// instruction ROM. Owns the fetch PC and reads one ROM word per cycle while
// the queue has room. It buffers {pc, inst} pairs in a DEPTH-entry FIFO and
// hands them to decode over a valid/ready handshake. A redirect flushes the
// queue and restarts fetch at the new (word-aligned) PC.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   When defined, an empty queue presents the ROM word directly on the
//   decode outputs in the same cycle. If decode takes it, it is never written.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   rom_ce_o       out  ROM chip enable (a word is fetched this cycle)
//   rom_addr_o     out  ROM byte address (current fetch PC)
//   rom_data_i     in   ROM word, valid in the same cycle
//   redirect_i     in   flush and refetch from redirect_pc_i
//   redirect_pc_i  in   new fetch PC, bits [1:0] ignored
//   if_valid_o     out  head entry valid
//   if_pc_o        out  head entry PC
//   if_inst_o      out  head entry instruction
//   id_ready_i     in   decode accepts head entry this cycle
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  input  logic        id_ready_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [AW-1:0] P_ONE   = AW'(1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_can_fetch;
  logic w_space;
  logic w_bypass;
  logic w_bypass_take;
  logic w_pop;
  logic w_push;
  logic w_write;
  logic w_read;

  assign w_can_fetch = rst & ~redirect_i;
  assign w_space     = (r_count < C_DEPTH);

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue always has room, so this path never depends on pop and
  // there is no combinational loop through push/pop/valid.
  assign w_bypass      = w_can_fetch & (r_count == '0);
  assign w_bypass_take = w_bypass & id_ready_i;
  assign if_valid_o    = ((r_count != '0) & ~redirect_i) | w_bypass;
  assign if_pc_o       = w_bypass ? r_fetch_pc : r_pc_mem[r_rd_ptr];
  assign if_inst_o     = w_bypass ? rom_data_i : r_inst_mem[r_rd_ptr];
`else
  assign w_bypass      = 1'b0;
  assign w_bypass_take = 1'b0;
  assign if_valid_o    = (r_count != '0) & ~redirect_i;
  assign if_pc_o       = r_pc_mem[r_rd_ptr];
  assign if_inst_o     = r_inst_mem[r_rd_ptr];
`endif

  assign w_pop  = if_valid_o & id_ready_i;
  assign w_push = w_can_fetch & (w_space | w_pop);

  // A bypassed word that decode consumes never touches the storage.
  assign w_write = w_push & ~w_bypass_take;
  assign w_read  = w_pop  & ~w_bypass_take;

  assign rom_ce_o   = w_push;
  assign rom_addr_o = r_fetch_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (redirect_i) begin
      r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_write) begin
        r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
        r_inst_mem[r_wr_ptr] <= rom_data_i;
        r_wr_ptr             <= r_wr_ptr + P_ONE;
      end
      if (w_read) begin
        r_rd_ptr <= r_rd_ptr + P_ONE;
      end
      case ({w_write, w_read})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        id_ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_ce_o     (rom_ce_o),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .if_valid_o   (if_valid_o),
    .if_pc_o      (if_pc_o),
    .if_inst_o    (if_inst_o),
    .id_ready_i   (id_ready_i)
  );

  // ROM: word i holds value i
  assign rom_data_i = {2'b00, rom_addr_o[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic        cd;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        ece;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic redir, input logic [31:0] rpc, input logic rdy,
                     input logic ev, input logic cd, input logic [31:0] epc,
                     input logic [31:0] einst, input logic ece, input logic [31:0] eaddr);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.cd = cd;
    v.epc = epc; v.einst = einst; v.ece = ece; v.eaddr = eaddr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int waited;
    rst           = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    id_ready_i    = 1'b0;

    //  redir rpc           rdy ev cd epc           einst         ce addr
    add(0, 32'h0,          1, 0, 0, 32'h0,        32'h0,        1, 32'h0);
    add(0, 32'h0,          1, 1, 1, 32'h0,        32'h0,        1, 32'h4);
    add(0, 32'h0,          1, 1, 1, 32'h4,        32'h1,        1, 32'h8);
    add(0, 32'h0,          1, 1, 1, 32'h8,        32'h2,        1, 32'hC);
    add(0, 32'h0,          1, 1, 1, 32'hC,        32'h3,        1, 32'h10);
    add(0, 32'h0,          0, 1, 1, 32'h10,       32'h4,        1, 32'h14);
    add(0, 32'h0,          0, 1, 1, 32'h10,       32'h4,        1, 32'h18);
    add(0, 32'h0,          0, 1, 1, 32'h10,       32'h4,        1, 32'h1C);
    add(0, 32'h0,          0, 1, 1, 32'h10,       32'h4,        0, 32'h20);
    add(0, 32'h0,          1, 1, 1, 32'h10,       32'h4,        1, 32'h20);
    add(0, 32'h0,          0, 1, 1, 32'h14,       32'h5,        0, 32'h24);
    add(1, 32'h103,        0, 0, 0, 32'h0,        32'h0,        0, 32'h24);
    add(0, 32'h0,          1, 0, 0, 32'h0,        32'h0,        1, 32'h100);
    add(0, 32'h0,          1, 1, 1, 32'h100,      32'h40,       1, 32'h104);
    add(1, 32'hFFFF_FFF9,  1, 0, 0, 32'h0,        32'h0,        0, 32'h108);
    add(0, 32'h0,          1, 0, 0, 32'h0,        32'h0,        1, 32'hFFFF_FFF8);
    add(0, 32'h0,          1, 1, 1, 32'hFFFF_FFF8, 32'h3FFF_FFFE, 1, 32'hFFFF_FFFC);
    add(0, 32'h0,          1, 1, 1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 1, 32'h0);
    add(0, 32'h0,          1, 1, 1, 32'h0,        32'h0,        1, 32'h4);
    add(1, 32'h200,        1, 0, 0, 32'h0,        32'h0,        0, 32'h8);
    add(1, 32'h300,        1, 0, 0, 32'h0,        32'h0,        0, 32'h200);
    add(0, 32'h0,          1, 0, 0, 32'h0,        32'h0,        1, 32'h300);
    add(0, 32'h0,          1, 1, 1, 32'h300,      32'hC0,       1, 32'h304);

    // reset state while held
    @(negedge clk);
    #1;
    chk("reset_valid", {31'b0, if_valid_o}, 32'h0);
    chk("reset_ce",    {31'b0, rom_ce_o},   32'h0);
    chk("reset_addr",  rom_addr_o,          32'h0);
    chk("reset_pc",    if_pc_o,             32'h0);
    chk("reset_inst",  if_inst_o,           32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b1;
      redirect_i    = vecs[i].redir;
      redirect_pc_i = vecs[i].rpc;
      id_ready_i    = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_valid", i), {31'b0, if_valid_o}, {31'b0, vecs[i].ev});
      chk($sformatf("v%0d_ce", i),    {31'b0, rom_ce_o},   {31'b0, vecs[i].ece});
      chk($sformatf("v%0d_addr", i),  rom_addr_o,          vecs[i].eaddr);
      if (vecs[i].cd) begin
        chk($sformatf("v%0d_pc", i),   if_pc_o,   vecs[i].epc);
        chk($sformatf("v%0d_inst", i), if_inst_o, vecs[i].einst);
      end
    end

    // asynchronous reset between clock edges, mid-stream
    #2;
    rst = 1'b0;
    #1;
    chk("async_valid", {31'b0, if_valid_o}, 32'h0);
    chk("async_ce",    {31'b0, rom_ce_o},   32'h0);
    chk("async_addr",  rom_addr_o,          32'h0);
    chk("async_pc",    if_pc_o,             32'h0);
    chk("async_inst",  if_inst_o,           32'h0);

    @(negedge clk);
    @(negedge clk);
    rst        = 1'b1;
    redirect_i = 1'b0;
    id_ready_i = 1'b1;
    #1;
    chk("rel_valid", {31'b0, if_valid_o}, 32'h0);
    chk("rel_ce",    {31'b0, rom_ce_o},   32'h1);
    chk("rel_addr",  rom_addr_o,          32'h0);

    waited = 0;
    while (waited < 5) begin
      @(negedge clk);
      #1;
      waited++;
      if (if_valid_o) break;
    end
    chk("rel_latency", waited, 1);
    chk("rel_first_pc",   if_pc_o,   32'h0);
    chk("rel_first_inst", if_inst_o, 32'h0);
    @(negedge clk);
    #1;
    chk("rel_second_pc", if_pc_o, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
